// File: rtl/kf76489_pkg.sv
// kf76489_pkg: constants and types shared by the KF76489 sound core blocks.
//
// Contents:
//   rate_e      - noise shift-rate codes as written to bus[7:6]
//   feedback_e  - noise feedback mode as written to bus[5]
//   ATTEN_WIDTH - attenuation register width (4 bits, F = off)
//   LEVEL_WIDTH - mixer input width (6 bits)
//   DEFAULT_LFSR_WIDTH, DEFAULT_TAP_MASK, default_seed() - noise LFSR defaults
package kf76489_pkg;

  // The two divided rates use a bit-reversed encoding, matching the
  // original register layout.
  typedef enum logic [1:0] {
    RATE_N512  = 2'b00,
    RATE_N1024 = 2'b10,
    RATE_N2048 = 2'b01,
    RATE_EXT   = 2'b11
  } rate_e;

  typedef enum logic {
    FB_PERIODIC = 1'b0,
    FB_WHITE    = 1'b1
  } feedback_e;

  localparam int unsigned ATTEN_WIDTH = 4;
  localparam int unsigned LEVEL_WIDTH = 6;
  localparam logic [ATTEN_WIDTH-1:0] ATTEN_OFF = 4'hF;

  localparam int unsigned DEFAULT_LFSR_WIDTH = 15;
  localparam logic [31:0] DEFAULT_TAP_MASK   = 32'h0000_0011;

  // Default seed for a register of the given width: only the MSB set.
  function automatic logic [31:0] default_seed(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/KF76489_Attenuation.sv
// KF76489_Attenuation: shared attenuation stage of the KF76489 sound core.
// Maps a 4-bit attenuation code (2 dB per step, F = off) and a 1-bit channel
// level onto a 6-bit mixer input. Purely combinational.
//
// Ports:
//   attenuation  in  4  attenuation code, 0 = loudest, F = silent
//   level_in     in  1  channel output bit
//   level        out 6  mixer level (0 when level_in is low or code is F)
module KF76489_Attenuation
  import kf76489_pkg::*;
(
  input  logic [ATTEN_WIDTH-1:0] attenuation,
  input  logic                   level_in,
  output logic [LEVEL_WIDTH-1:0] level
);

  // Table entries are round(63 * 10^(-code/10)), code F forced to zero.
  always_comb begin
    level = '0;
    if (level_in) begin
      case (attenuation)
        4'h0:    level = 6'd63;
        4'h1:    level = 6'd50;
        4'h2:    level = 6'd40;
        4'h3:    level = 6'd32;
        4'h4:    level = 6'd25;
        4'h5:    level = 6'd20;
        4'h6:    level = 6'd16;
        4'h7:    level = 6'd13;
        4'h8:    level = 6'd10;
        4'h9:    level = 6'd8;
        4'hA:    level = 6'd6;
        4'hB:    level = 6'd5;
        4'hC:    level = 6'd4;
        4'hD:    level = 6'd3;
        4'hE:    level = 6'd3;
        default: level = 6'd0;
      endcase
    end
  end

endmodule

// File: rtl/kf76489_noise_lfsr.sv
// kf76489_noise_lfsr: noise channel of the KF76489 sound core.
// One LFSR (periodic rotate or white XOR feedback) shifted either by a
// three-stage prescaler running off clock_enable, or by rising edges of the
// external tone-channel signal. Output goes through the shared attenuation
// stage onto one mixer input.
//
// Optional feature macro: KF76489_NOISE_ZERO_LOCK_EN
//   defined   - a shift out of, or into, the all-zero state loads the MSB-only
//               value instead, so the channel can never stall.
//   undefined - the all-zero state is held until the next control write.
//
// Ports:
//   reset                    in  1  asynchronous, active-high
//   clock                    in  1  system clock
//   clock_enable             in  1  chip-clock enable
//   internal_data_bus        in  8  register write data
//   write_noise_control      in  1  bus[7:6] rate, bus[5] feedback; reloads SEED
//   write_noise_attenuation  in  1  bus[7:4] attenuation
//   ext_noise_gen            in  1  external shift source (tone channel 3)
//   noise_out                out 1  lfsr[0]
//   analog_out               out 6  attenuated noise level
module kf76489_noise_lfsr
  import kf76489_pkg::*;
#(
  parameter int unsigned             LFSR_WIDTH = DEFAULT_LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0]   TAP_MASK   = LFSR_WIDTH'(DEFAULT_TAP_MASK),
  parameter logic [LFSR_WIDTH-1:0]   SEED       = LFSR_WIDTH'(default_seed(LFSR_WIDTH)),
  parameter int unsigned             PRESCALE   = 16
)(
  input  logic                   reset,
  input  logic                   clock,
  input  logic                   clock_enable,
  input  logic [7:0]             internal_data_bus,
  input  logic                   write_noise_control,
  input  logic                   write_noise_attenuation,
  input  logic                   ext_noise_gen,
  output logic                   noise_out,
  output logic [LEVEL_WIDTH-1:0] analog_out
);

  localparam int unsigned     CNT_W    = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

`ifdef KF76489_NOISE_ZERO_LOCK_EN
  localparam logic [LFSR_WIDTH-1:0] LOCK_VALUE = LFSR_WIDTH'(default_seed(LFSR_WIDTH));
`endif

  // Register state
  rate_e                   rate;
  feedback_e               feedback;
  logic [ATTEN_WIDTH-1:0]  attenuation;
  logic [LFSR_WIDTH-1:0]   lfsr;

  // Prescaler state
  logic [CNT_W-1:0]        pre_count;
  logic                    t1;
  logic                    t2;
  logic                    t3;
  logic                    ext_q;

  // Derived enables
  logic                    base_en;
  logic                    s1_en;
  logic                    s2_en;
  logic                    s3_en;
  logic                    ext_edge;
  logic                    shift;
  logic                    fb;
  logic [LFSR_WIDTH-1:0]   lfsr_step;

  // Low nibble of the bus carries no noise-channel fields.
  logic                    unused_bus_bits;
  assign unused_bus_bits = ^internal_data_bus[3:0];

  // ---------------------------------------------------------------------------
  // Prescaler: free-running, never cleared by register writes. Each stage
  // passes every other enable of the stage before it, so the first enable of
  // every stage lines up on the PRESCALE-th chip enable after reset.
  // ---------------------------------------------------------------------------
  assign base_en  = clock_enable & (pre_count == CNT_LAST);
  assign s1_en    = base_en & ~t1;
  assign s2_en    = s1_en & ~t2;
  assign s3_en    = s2_en & ~t3;
  assign ext_edge = ext_noise_gen & ~ext_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_count <= '0;
      t1        <= 1'b0;
      t2        <= 1'b0;
      t3        <= 1'b0;
      ext_q     <= 1'b0;
    end else begin
      // ext_q runs on every clock so external edges work with the chip
      // clock stopped.
      ext_q <= ext_noise_gen;
      if (clock_enable) pre_count <= pre_count + 1'b1;
      if (base_en)      t1 <= ~t1;
      if (s1_en)        t2 <= ~t2;
      if (s2_en)        t3 <= ~t3;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift source selection
  // ---------------------------------------------------------------------------
  always_comb begin
    shift = 1'b0;
    case (rate)
      RATE_N512:  shift = s1_en;
      RATE_N1024: shift = s2_en;
      RATE_N2048: shift = s3_en;
      RATE_EXT:   shift = ext_edge;
      default:    shift = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next LFSR value for a shift: new bit enters at the MSB.
  // ---------------------------------------------------------------------------
  always_comb begin
    fb = lfsr[0];
    if (feedback == FB_WHITE) fb = ^(lfsr & TAP_MASK);
    lfsr_step = {fb, lfsr[LFSR_WIDTH-1:1]};
`ifdef KF76489_NOISE_ZERO_LOCK_EN
    if ((lfsr_step == '0) || (lfsr == '0)) lfsr_step = LOCK_VALUE;
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers. A control write takes priority over a coincident shift.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rate        <= RATE_N512;
      feedback    <= FB_PERIODIC;
      attenuation <= ATTEN_OFF;
      lfsr        <= SEED;
    end else begin
      if (write_noise_attenuation) attenuation <= internal_data_bus[7:4];
      if (write_noise_control) begin
        rate     <= rate_e'(internal_data_bus[7:6]);
        feedback <= feedback_e'(internal_data_bus[5]);
        lfsr     <= SEED;
      end else if (shift) begin
        lfsr <= lfsr_step;
      end
    end
  end

  assign noise_out = lfsr[0];

  KF76489_Attenuation u_attenuation (
    .attenuation (attenuation),
    .level_in    (noise_out),
    .level       (analog_out)
  );

endmodule
